dm_arbiter: RTL

Two-requester arbiter for the single data-memory port (m_data_addr/m_data_wdata/m_data_byteen/m_data_rdata) of the pipelined MIPS core. It shares that port between the CPU MEM stage and a DMA/debug requester. The CPU has priority, but a starvation counter and a locked-burst mode bound the DMA's wait. When the CPU loses arbitration, the block raises a stall to the pipeline. It sits between the `mips` MEM stage and the byte-enabled data memory, which reads combinationally and writes on posedge when any byteen bit is set.

---
 rtl/dm_arb_pkg.sv | 13 +
 rtl/dm_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU MEM
// stage and the DMA/debug requester.
package dm_arb_pkg;

    typedef enum logic [0:0] {
        CPU_PRI  = 1'b0,
        DMA_LOCK = 1'b1
    } arb_state_t;

    localparam logic [31:0] DMA_PC_TAG  = 32'hFFFF_FFFF;
    localparam logic [3:0]  BYTEEN_NONE = 4'b0000;

endpackage

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single data-memory port: CPU has priority,
// a starvation counter and bounded locked bursts limit the DMA's wait.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_byteen,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_inst_addr
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
    localparam logic [BW-1:0] BEAT_ONE   = BW'(1);

    arb_state_t    state_r;
    arb_state_t    state_s;
    logic [WW-1:0] wait_cnt_r;
    logic [WW-1:0] wait_cnt_s;
    logic [BW-1:0] beat_cnt_r;
    logic [BW-1:0] beat_cnt_s;
    logic [31:0]   dma_rdata_r;
    logic          dma_rvalid_r;
    logic          dma_rvalid_s;
    logic          cpu_gnt_s;
    logic          dma_gnt_s;

    // Grant decision; reset suppresses both grants so nothing reaches memory.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dma_gnt_s = 1'b0;
        if (reset) begin
            cpu_gnt_s = 1'b0;
            dma_gnt_s = 1'b0;
        end else begin
            case (state_r)
                CPU_PRI: begin
                    if (cpu_req && (!dma_req || (wait_cnt_r < MAX_WAIT_C))) begin
                        cpu_gnt_s = 1'b1;
                    end else begin
                        dma_gnt_s = dma_req;
                    end
                end
                DMA_LOCK: begin
                    if (dma_req) begin
                        dma_gnt_s = 1'b1;
                    end else begin
                        cpu_gnt_s = cpu_req;
                    end
                end
                default: begin
                    cpu_gnt_s = cpu_req;
                end
            endcase
        end
    end

    // Next state, starvation counter and burst beat counter.
    always_comb begin
        state_s      = CPU_PRI;
        wait_cnt_s   = wait_cnt_r;
        beat_cnt_s   = '0;
        dma_rvalid_s = dma_gnt_s && (dma_byteen == BYTEEN_NONE);
        if (dma_gnt_s) begin
            wait_cnt_s = '0;
            // The final beat of a burst always hands the port back to the CPU.
            if (beat_cnt_r == BURST_LAST) begin
                state_s    = CPU_PRI;
                beat_cnt_s = '0;
            end else if (dma_lock) begin
                state_s    = DMA_LOCK;
                beat_cnt_s = beat_cnt_r + BEAT_ONE;
            end else begin
                state_s    = CPU_PRI;
                beat_cnt_s = '0;
            end
        end else begin
            state_s    = CPU_PRI;
            beat_cnt_s = '0;
            if (!dma_req) begin
                wait_cnt_s = '0;
            end else if (cpu_gnt_s) begin
                wait_cnt_s = wait_cnt_r + WAIT_ONE;
            end else begin
                wait_cnt_s = wait_cnt_r;
            end
        end
    end

    // State register plus the registered DMA read return path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= CPU_PRI;
            wait_cnt_r   <= '0;
            beat_cnt_r   <= '0;
            dma_rvalid_r <= 1'b0;
            dma_rdata_r  <= 32'h0000_0000;
        end else begin
            state_r      <= state_s;
            wait_cnt_r   <= wait_cnt_s;
            beat_cnt_r   <= beat_cnt_s;
            dma_rvalid_r <= dma_rvalid_s;
            dma_rdata_r  <= dma_rvalid_s ? m_data_rdata : dma_rdata_r;
        end
    end

    // Memory port mux and pipeline-facing outputs.
    always_comb begin
        m_data_addr   = cpu_addr;
        m_data_wdata  = 32'h0000_0000;
        m_data_byteen = BYTEEN_NONE;
        m_inst_addr   = cpu_pc;
        if (cpu_gnt_s) begin
            m_data_addr   = cpu_addr;
            m_data_wdata  = cpu_wdata;
            m_data_byteen = cpu_byteen;
            m_inst_addr   = cpu_pc;
        end else if (dma_gnt_s) begin
            m_data_addr   = dma_addr;
            m_data_wdata  = dma_wdata;
            m_data_byteen = dma_byteen;
            m_inst_addr   = DMA_PC_TAG;
        end else begin
            m_data_addr   = cpu_addr;
            m_data_wdata  = 32'h0000_0000;
            m_data_byteen = BYTEEN_NONE;
            m_inst_addr   = cpu_pc;
        end
    end

    assign cpu_rdata  = m_data_rdata;
    assign cpu_stall  = cpu_req & ~cpu_gnt_s & ~reset;
    assign dma_gnt    = dma_gnt_s;
    assign dma_rdata  = dma_rdata_r;
    assign dma_rvalid = dma_rvalid_r;

endmodule
